// File: rtl/adder_scheduler_pkg.sv
// Shared types and default timing for the adder scheduler.
// The enum encodes the one-operation-at-a-time issue sequence.
package adder_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam int DEF_SHORT_CYCLES = 8;
   localparam int DEF_LONG_CYCLES  = 16;
   localparam int DEF_MID_LO       = 14;
   localparam int DEF_MID_HI       = 17;

endpackage

// File: rtl/adder_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first active request at or above ptr, with wrap.
// Returns a one-hot grant, its encoded index, and whether any request won.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
         if (!any && req[cand]) begin
            any         = 1'b1;
            idx         = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_scheduler.sv
// Round-robin scheduler sharing one dynamic-latency adder; completion is timed
// locally from the operands' middle propagate window instead of the adder's ready.
//
//   state | meaning
//   IDLE  | offer req_ready to the arbitration winner, capture operands on handshake
//   ISSUE | pulse add_start, load latency counter, bump long_count if long
//   WAIT  | count down; at count 1 capture sum/carry
//   RESP  | present result to owner until its resp_ready
module adder_scheduler
   import adder_scheduler_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int WIDTH        = 32,
   parameter int SHORT_CYCLES = adder_scheduler_pkg::DEF_SHORT_CYCLES,
   parameter int LONG_CYCLES  = adder_scheduler_pkg::DEF_LONG_CYCLES,
   parameter int MID_LO       = adder_scheduler_pkg::DEF_MID_LO,
   parameter int MID_HI       = adder_scheduler_pkg::DEF_MID_HI
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   input  logic [NUM_REQ-1:0]       req_cin,
   output logic [WIDTH-1:0]         add_a,
   output logic [WIDTH-1:0]         add_b,
   output logic                     add_cin,
   output logic                     add_start,
   input  logic [WIDTH-1:0]         add_sum,
   input  logic                     add_cout,
   output logic [NUM_REQ-1:0]       resp_valid,
   input  logic [NUM_REQ-1:0]       resp_ready,
   output logic [WIDTH-1:0]         resp_sum,
   output logic                     resp_cout,
   output logic                     busy,
   output logic [15:0]              long_count
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(LONG_CYCLES + 1);

   state_e                state, state_nxt;
   logic [IDX_W-1:0]      ptr;
   logic [IDX_W-1:0]      grant_idx;
   logic                  is_long;
   logic [CNT_W-1:0]      cnt;

   logic [NUM_REQ-1:0]    arb_grant;
   logic [IDX_W-1:0]      arb_idx;
   logic                  arb_any;
   logic [WIDTH-1:0]      sel_a;
   logic [WIDTH-1:0]      sel_b;
   logic [MID_HI:MID_LO]  sel_prop;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   assign sel_a    = req_a[int'(arb_idx)*WIDTH +: WIDTH];
   assign sel_b    = req_b[int'(arb_idx)*WIDTH +: WIDTH];
   assign sel_prop = sel_a[MID_HI:MID_LO] ^ sel_b[MID_HI:MID_LO];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = '0;
      resp_valid = '0;
      add_start  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy      = 1'b0;
            req_ready = arb_grant;
            if (arb_any) state_nxt = ISSUE;
         end
         ISSUE: begin
            add_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (cnt == CNT_W'(1)) state_nxt = RESP;
         end
         RESP: begin
            resp_valid = NUM_REQ'(1) << grant_idx;
            if (resp_ready[grant_idx]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr        <= '0;
         grant_idx  <= '0;
         is_long    <= 1'b0;
         cnt        <= '0;
         add_a      <= '0;
         add_b      <= '0;
         add_cin    <= 1'b0;
         resp_sum   <= '0;
         resp_cout  <= 1'b0;
         long_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_any) begin
                  add_a     <= sel_a;
                  add_b     <= sel_b;
                  add_cin   <= req_cin[arb_idx];
                  grant_idx <= arb_idx;
                  is_long   <= &sel_prop;
               end
            end
            ISSUE: begin
               cnt <= is_long ? CNT_W'(LONG_CYCLES) : CNT_W'(SHORT_CYCLES);
               if (is_long && long_count != 16'hFFFF) long_count <= long_count + 16'd1;
            end
            WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  resp_sum  <= add_sum;
                  resp_cout <= add_cout;
               end
            end
            RESP: begin
               // pointer moves past the owner only once its result is taken
               if (resp_ready[grant_idx])
                  ptr <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_scheduler.sv
// Directed bench for adder_scheduler with a behavioural adder behind it.
module tb_adder_scheduler;

   localparam int N = 4;
   localparam int W = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*W-1:0]   req_a;
   logic [N*W-1:0]   req_b;
   logic [N-1:0]     req_cin;
   logic [W-1:0]     add_a;
   logic [W-1:0]     add_b;
   logic             add_cin;
   logic             add_start;
   logic [W-1:0]     add_sum;
   logic             add_cout;
   logic [N-1:0]     resp_valid;
   logic [N-1:0]     resp_ready;
   logic [W-1:0]     resp_sum;
   logic             resp_cout;
   logic             busy;
   logic [15:0]      long_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

   adder_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_cin    (req_cin),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_cin    (add_cin),
      .add_start  (add_start),
      .add_sum    (add_sum),
      .add_cout   (add_cout),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_sum   (resp_sum),
      .resp_cout  (resp_cout),
      .busy       (busy),
      .long_count (long_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input int exp_l, input logic [W-1:0] exp_sum,
                         input logic exp_cout, input logic [15:0] exp_lc, input string tag);
      int cyc;
      int starts;
      @(negedge clk);
      req_a[idx*W +: W] = a;
      req_b[idx*W +: W] = b;
      req_cin[idx]      = cin;
      req_valid[idx]    = 1'b1;
      #1 chk({tag, "_req_ready"}, req_ready, 64'(1 << idx));
      @(negedge clk);
      // operands scrambled after the handshake must not reach the adder
      req_valid[idx]    = 1'b0;
      req_a[idx*W +: W] = ~a;
      req_b[idx*W +: W] = ~b;
      cyc    = 1;
      starts = int'(add_start);
      chk({tag, "_start_t1"}, add_start, 1);
      chk({tag, "_add_a"}, add_a, a);
      while (resp_valid == '0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (add_start) starts++;
      end
      chk({tag, "_latency"}, cyc, exp_l + 2);
      chk({tag, "_resp_valid"}, resp_valid, 64'(1 << idx));
      chk({tag, "_sum"}, resp_sum, exp_sum);
      chk({tag, "_cout"}, resp_cout, exp_cout);
      chk({tag, "_start_count"}, starts, 1);
      chk({tag, "_long_count"}, long_count, exp_lc);
   endtask

   initial begin
      int order [5];
      int tgr [5];
      int ngr;
      int multi;
      int stray;

      reset      = 1'b0;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      req_cin    = '0;
      resp_ready = 4'b1111;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_add_start", add_start, 0);
      chk("rst_operands", {add_a, add_b}, 0);
      chk("rst_long_count", long_count, 0);
      @(negedge clk);
      reset = 1'b1;

      // short and long latency single operations
      run_op(0, 32'd5, 32'd3, 1'b0, 8, 32'd8, 1'b0, 16'd0, "op0_short");
      run_op(1, 32'h0003C000, 32'd0, 1'b0, 16, 32'h0003C000, 1'b0, 16'd1, "op1_long");

      // all requesters continuously valid from a fresh pointer
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = 32'(i + 1);
         req_b[i*W +: W] = 32'h10;
      end
      req_valid = 4'b1111;
      ngr   = 0;
      multi = 0;
      for (int c = 0; c < 80; c++) begin
         #1;
         if ($countones(req_ready) > 1) multi++;
         if (req_ready != '0) begin
            for (int k = 0; k < N; k++) if (req_ready[k]) order[ngr] = k;
            tgr[ngr] = c;
            ngr++;
         end
         if (ngr == 5) break;
         @(negedge clk);
      end
      @(negedge clk);
      req_valid = '0;
      chk("rr_grant_count", ngr, 5);
      chk("rr_onehot", multi, 0);
      chk("rr_order", {order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0], order[4][3:0]},
          20'h01230);
      chk("rr_gap", {tgr[1] - tgr[0], tgr[2] - tgr[1], tgr[3] - tgr[2], tgr[4] - tgr[3]},
          {32'd11, 32'd11} );
      chk("rr_gap_tail", {tgr[3] - tgr[2], tgr[4] - tgr[3]}, {32'd11, 32'd11});
      repeat (12) @(negedge clk);

      // overflowing add with the owner stalling its response
      resp_ready = 4'b1011;
      run_op(2, 32'hFFFFFFFF, 32'd1, 1'b0, 16, 32'd0, 1'b1, 16'd1, "op2_wrap");
      req_valid[0] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("hold_outputs", {busy, resp_valid, resp_cout, req_ready, resp_sum},
             {1'b1, 4'b0100, 1'b1, 4'b0000, 32'h0});
      end
      resp_ready = 4'b1111;
      @(negedge clk);
      chk("release_resp_valid", resp_valid, 0);
      chk("release_next_grant", req_ready, 4'b0001);
      req_valid = '0;

      // reset abandons an in-flight operation from requester 3
      @(negedge clk);
      req_a[3*W +: W] = 32'd100;
      req_b[3*W +: W] = 32'd23;
      req_valid[3]    = 1'b1;
      #1 chk("r3_req_ready", req_ready, 4'b1000);
      @(negedge clk);
      req_valid = '0;
      repeat (4) @(negedge clk);
      chk("r3_in_wait", {busy, resp_valid}, {1'b1, 4'b0000});
      #2 reset = 1'b0;
      #1;
      chk("async_rst_outputs", {busy, add_start, resp_valid}, 0);
      chk("async_rst_long_count", long_count, 0);
      @(negedge clk);
      reset = 1'b1;
      stray = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (resp_valid != '0 || busy) stray++;
      end
      chk("no_resp_after_rst", stray, 0);
      req_valid = 4'b1111;
      #1 chk("ptr_after_rst", req_ready, 4'b0001);
      req_valid = '0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
